// File: rtl/chipbus_slot_arbiter.sv
// chipbus_slot_arbiter
// Splits the master clock into bus slots of SLOT_CLKS cycles and hands each
// slot to Agnus DMA, the 68000, or nobody. DMA has priority. CPU cycles end
// with _DTACK; an XRDY-low sample stretches the CPU cycle by a whole slot.
// Optional feature: define CHIPBUS_ARB_FAIRNESS_EN to build the deny counter
// that lets a starved CPU win one slot over a non-urgent DMA request.
module chipbus_slot_arbiter #(
  parameter int SLOT_CLKS = 8,
  parameter int MAX_WAIT  = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         DMA_REQ,
  input  logic                         DMA_URGENT,
  input  logic                         CPU_SEL,
  input  logic                         XRDY,
  output logic [$clog2(SLOT_CLKS)-1:0] SLOT_PH,
  output logic                         SLOT_START,
  output logic                         DMA_GNT,
  output logic                         CPU_GNT,
  output logic                         DMA_MISS,
  output logic                         _DBR,
  output logic                         _DTACK
);

  localparam int PH_W = $clog2(SLOT_CLKS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CLKS - 1);
  localparam logic [PH_W-1:0] PH_XRDY = PH_W'(SLOT_CLKS - 2);

  typedef enum logic [1:0] {IDLE, DMA_ACC, CPU_ACC, ACKED} state_t;

  state_t state;
  logic   run;        // low until the first slot after reset has begun
  logic   ext;        // XRDY was low: the CPU keeps the next slot
  logic   armed;      // CPU_SEL seen low since the last acknowledge/reset
  logic   slot_edge;  // this edge enters phase 0
  logic   ext_live;
  logic   cpu_pend;
  logic   fair_win;
  logic   cpu_win;
  logic   dma_win;
  logic   acked_nxt;
  logic   dma_nxt;

  // The first edge after reset starts slot 0; afterwards every wrap does.
  assign slot_edge = !run || (SLOT_PH == PH_LAST);

`ifdef CHIPBUS_ARB_FAIRNESS_EN
  localparam int DENY_W = $clog2(MAX_WAIT) + 1;
  logic [DENY_W-1:0] deny;

  // Count slots the pending CPU lost to DMA; any CPU grant or a released
  // CPU_SEL starts the count over.
  always_ff @(posedge CLK) begin
    if (RST || !CPU_SEL)
      deny <= '0;
    else if (slot_edge) begin
      if (cpu_win)
        deny <= '0;
      else if (cpu_pend && dma_win && deny != '1)
        deny <= deny + DENY_W'(1);
    end
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  logic unused_urgent;
  assign unused_urgent = DMA_URGENT;
`endif

  // Slot owner decision and the look-ahead terms that feed _DBR.
  always_comb begin
    // An abort (CPU_SEL low) also kills a pending extension.
    ext_live = ext && CPU_SEL;
    cpu_pend = CPU_SEL && armed;
    fair_win = 1'b0;
`ifdef CHIPBUS_ARB_FAIRNESS_EN
    fair_win = cpu_pend && !DMA_URGENT && (deny >= DENY_W'(MAX_WAIT));
`endif
    cpu_win   = ext_live || fair_win || (!DMA_REQ && cpu_pend);
    dma_win   = DMA_REQ && !cpu_win;
    acked_nxt = (state == ACKED && CPU_SEL) ||
                (state == CPU_ACC && CPU_SEL && SLOT_PH == PH_XRDY && XRDY);
    dma_nxt   = slot_edge ? dma_win : DMA_GNT;
  end

  // Phase counter, grants and the CPU cycle FSM; all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run        <= 1'b0;
      SLOT_PH    <= '0;
      SLOT_START <= 1'b0;
      DMA_GNT    <= 1'b0;
      CPU_GNT    <= 1'b0;
      DMA_MISS   <= 1'b0;
      _DBR       <= 1'b1;
      _DTACK     <= 1'b1;
      state      <= IDLE;
      ext        <= 1'b0;
      armed      <= 1'b0;
    end else begin
      run        <= 1'b1;
      SLOT_PH    <= run ? SLOT_PH + PH_W'(1) : '0;
      SLOT_START <= slot_edge;
      DMA_MISS   <= slot_edge && DMA_REQ && !dma_win;
      _DBR       <= !(dma_nxt && CPU_SEL && !acked_nxt);
      if (!CPU_SEL)
        armed <= 1'b1;

      case (state)
        ACKED: begin
          if (!CPU_SEL) begin
            _DTACK <= 1'b1;
            state  <= IDLE;
          end
        end
        CPU_ACC: begin
          if (!CPU_SEL) begin
            // Aborted cycle: slot stays owned, no acknowledge.
            state <= IDLE;
            ext   <= 1'b0;
          end else if (SLOT_PH == PH_XRDY) begin
            if (XRDY) begin
              state  <= ACKED;
              _DTACK <= 1'b0;
              ext    <= 1'b0;
              armed  <= 1'b0;
            end else begin
              ext <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (slot_edge) begin
        DMA_GNT <= dma_win;
        CPU_GNT <= cpu_win;
        if (cpu_win)
          state <= CPU_ACC;
        else if (state != ACKED)
          state <= dma_win ? DMA_ACC : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_chipbus_slot_arbiter.sv
// Bench for chipbus_slot_arbiter: directed scenarios plus random traffic,
// all cycles checked against a slot/deadline level reference model.
module tb_chipbus_slot_arbiter;
  localparam int SLOT_CLKS = 8;
  localparam int MAX_WAIT  = 3;
  localparam int PH_W      = $clog2(SLOT_CLKS);
  localparam logic [PH_W+5:0] RST_VEC = {{PH_W{1'b0}}, 6'b000011};

  logic clk = 1'b0;
  logic rst = 1'b1, dma_req = 1'b0, dma_urgent = 1'b0, cpu_sel = 1'b0, xrdy = 1'b1;
  logic [PH_W-1:0] slot_ph;
  logic slot_start, dma_gnt, cpu_gnt, dma_miss, dbr, dtack;
  logic [PH_W+5:0] obs;
  int n_chk = 0;
  int n_bad = 0;

  assign obs = {slot_ph, slot_start, dma_gnt, cpu_gnt, dma_miss, dbr, dtack};

  chipbus_slot_arbiter #(.SLOT_CLKS(SLOT_CLKS), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(clk), .RST(rst), .DMA_REQ(dma_req), .DMA_URGENT(dma_urgent),
    .CPU_SEL(cpu_sel), .XRDY(xrdy), .SLOT_PH(slot_ph), .SLOT_START(slot_start),
    .DMA_GNT(dma_gnt), .CPU_GNT(cpu_gnt), .DMA_MISS(dma_miss),
    ._DBR(dbr), ._DTACK(dtack)
  );

  always #5 clk = ~clk;

  // Reference model: edges counted since reset, a CPU cycle tracked by the
  // edge at which its XRDY sample falls due.
  int   m_n, m_due, m_deny;
  bit   m_open, m_ext, m_acked, m_seen_low;
  logic [PH_W-1:0] e_ph;
  logic e_start, e_dgnt, e_cgnt, e_miss, e_dbr, e_dtack;

  function automatic void model_edge();
    bit bnd, ext_live, pend, fair, cpu, dma;
    if (rst) begin
      m_n = 0; m_due = 0; m_deny = 0;
      m_open = 0; m_ext = 0; m_acked = 0; m_seen_low = 0;
      e_ph = '0; e_start = 0; e_dgnt = 0; e_cgnt = 0; e_miss = 0;
      e_dbr = 1; e_dtack = 1;
      return;
    end
    m_n++;
    bnd      = ((m_n - 1) % SLOT_CLKS) == 0;
    e_ph     = PH_W'((m_n - 1) % SLOT_CLKS);
    e_start  = bnd;
    e_miss   = 0;
    ext_live = m_ext && cpu_sel;
    pend     = cpu_sel && m_seen_low;
    if (m_open) begin
      if (!cpu_sel) begin m_open = 0; m_ext = 0; end
      else if (m_n == m_due) begin
        if (xrdy) begin m_open = 0; m_ext = 0; m_acked = 1; m_seen_low = 0; end
        else m_ext = 1;
      end
    end else if (m_acked && !cpu_sel) m_acked = 0;
    if (!cpu_sel) begin m_seen_low = 1; m_deny = 0; end
    if (bnd) begin
      fair = 0;
`ifdef CHIPBUS_ARB_FAIRNESS_EN
      fair = pend && !dma_urgent && (m_deny >= MAX_WAIT);
`endif
      cpu    = ext_live || fair || (!dma_req && pend);
      dma    = dma_req && !cpu;
      e_miss = dma_req && !dma;
      e_cgnt = cpu;
      e_dgnt = dma;
      if (cpu) begin m_open = 1; m_due = m_n + SLOT_CLKS - 1; m_deny = 0; end
      else if (pend && dma) m_deny++;
    end
    e_dtack = !m_acked;
    e_dbr   = !(e_dgnt && cpu_sel && !m_acked);
  endfunction

  function automatic logic [PH_W+5:0] mvec();
    return {e_ph, e_start, e_dgnt, e_cgnt, e_miss, e_dbr, e_dtack};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_ph(input int p);
    int k = 0;
    while (int'(slot_ph) != p && k < 2 * SLOT_CLKS) begin tick(); k++; end
    if (int'(slot_ph) != p) begin
      n_chk++; n_bad++;
      $display("FAIL wait_ph timeout got %0d want %0d", slot_ph, p);
    end
  endtask

  task automatic test_reset();
    logic exp_s;
    for (int i = 0; i < 3; i++) begin
      dma_req = 1'($urandom_range(0, 1)); cpu_sel = 1'($urandom_range(0, 1));
      xrdy = 1'($urandom_range(0, 1));
      tick();
      n_chk++;
      if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_vals cyc %0d got %b want %b", i, obs, RST_VEC); end
    end
    dma_req = 0; cpu_sel = 0; xrdy = 1; rst = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_s = (k == 1) || (k == 9);
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL idle_model cyc %0d got %b want %b", k, obs, mvec()); end
      n_chk++;
      if (slot_start !== exp_s) begin n_bad++; $display("FAIL idle_start cyc %0d got %b want %b", k, slot_start, exp_s); end
      n_chk++;
      if ({dma_gnt, cpu_gnt, dbr, dtack} !== 4'b0011) begin
        n_bad++; $display("FAIL idle_outs cyc %0d got %b want 0011", k, {dma_gnt, cpu_gnt, dbr, dtack});
      end
    end
  endtask

  task automatic test_cpu_single();
    int t_g = -1, t_a = -1;
    logic [PH_W-1:0] ph_g = '1;
    wait_ph(3);
    cpu_sel = 1; xrdy = 1;
    for (int i = 0; i < 40 && t_a < 0; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL cpu_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (cpu_gnt === 1'b1 && t_g < 0) begin t_g = i; ph_g = slot_ph; end
      if (dtack === 1'b0 && t_a < 0) t_a = i;
    end
    n_chk++;
    if (t_g < 0 || t_a < 0 || t_a - t_g != SLOT_CLKS - 1) begin
      n_bad++; $display("FAIL cpu_dtack_latency got %0d want %0d", t_a - t_g, SLOT_CLKS - 1);
    end
    n_chk++;
    if (ph_g !== '0) begin n_bad++; $display("FAIL cpu_grant_phase got %0d want 0", ph_g); end
    cpu_sel = 0;
    tick();
    n_chk++;
    if (dtack !== 1'b1) begin n_bad++; $display("FAIL cpu_dtack_release got %b want 1", dtack); end
  endtask

  task automatic test_wait_states();
    int t_g = -1, t_a = -1, samples = 0, misses = 0;
    for (int i = 0; i < SLOT_CLKS; i++) tick();
    wait_ph(3);
    cpu_sel = 1; xrdy = 0; dma_req = 0;
    for (int i = 0; i < 60 && t_a < 0; i++) begin
      if (t_g >= 0 && int'(slot_ph) == SLOT_CLKS - 2) begin
        xrdy = (samples >= 2);
        samples++;
      end
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL wait_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (t_g >= 0 && dma_miss === 1'b1) misses++;
      if (cpu_gnt === 1'b1 && t_g < 0) begin t_g = i; dma_req = 1; end
      if (dtack === 1'b0 && t_a < 0) t_a = i;
    end
    n_chk++;
    if (t_g < 0 || t_a < 0 || t_a - t_g != 3 * SLOT_CLKS - 1) begin
      n_bad++; $display("FAIL wait_dtack_latency got %0d want %0d", t_a - t_g, 3 * SLOT_CLKS - 1);
    end
    n_chk++;
    if (misses != 2) begin n_bad++; $display("FAIL wait_dma_miss got %0d want 2", misses); end
    cpu_sel = 0; dma_req = 0; xrdy = 1;
  endtask

  task automatic test_dma_priority();
    int slot = 0, cpu_slot = 0, cpu_cnt = 0, misses = 0, dbr_hi = 0, dt_low = 0, dma_slots = 0;
    bit dma_seen = 0;
    dma_urgent = 0;
    for (int i = 0; i < SLOT_CLKS; i++) tick();
    wait_ph(3);
    dma_req = 1; cpu_sel = 1; xrdy = 1;
    for (int i = 0; i < 6 * SLOT_CLKS; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL prio_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (slot_start === 1'b1) begin
        slot++;
        if (dma_gnt === 1'b1) dma_slots++;
        if (cpu_gnt === 1'b1) begin cpu_cnt++; if (cpu_slot == 0) cpu_slot = slot; end
        if (dma_miss === 1'b1) misses++;
      end
      if (dma_gnt === 1'b1) dma_seen = 1;
      if (dma_seen && dbr !== 1'b0) dbr_hi++;
      if (dtack === 1'b0) dt_low++;
    end
`ifdef CHIPBUS_ARB_FAIRNESS_EN
    n_chk++;
    if (cpu_slot != MAX_WAIT + 1) begin n_bad++; $display("FAIL fair_cpu_slot got %0d want %0d", cpu_slot, MAX_WAIT + 1); end
    n_chk++;
    if (misses != 1) begin n_bad++; $display("FAIL fair_dma_miss got %0d want 1", misses); end
`else
    n_chk++;
    if (cpu_cnt != 0 || dt_low != 0) begin n_bad++; $display("FAIL prio_cpu_slots got %0d/%0d want 0/0", cpu_cnt, dt_low); end
    n_chk++;
    if (dma_slots != 6) begin n_bad++; $display("FAIL prio_dma_slots got %0d want 6", dma_slots); end
    n_chk++;
    if (dbr_hi != 0) begin n_bad++; $display("FAIL prio_dbr_high_cycles got %0d want 0", dbr_hi); end
`endif
    // Urgent DMA never yields, with or without the fairness override.
    dma_req = 0; cpu_sel = 0;
    for (int i = 0; i < SLOT_CLKS; i++) tick();
    wait_ph(3);
    dma_req = 1; cpu_sel = 1; dma_urgent = 1; cpu_cnt = 0;
    for (int i = 0; i < 6 * SLOT_CLKS; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL urgent_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (cpu_gnt === 1'b1) cpu_cnt++;
    end
    n_chk++;
    if (cpu_cnt != 0) begin n_bad++; $display("FAIL urgent_cpu_cycles got %0d want 0", cpu_cnt); end
    dma_req = 0; cpu_sel = 0; dma_urgent = 0;
  endtask

  task automatic test_reset_mid_ack();
    bit acked = 0, gnt = 0, ack2 = 0;
    int bad_cyc = 0;
    for (int i = 0; i < SLOT_CLKS; i++) tick();
    wait_ph(3);
    cpu_sel = 1; xrdy = 1;
    for (int i = 0; i < 3 * SLOT_CLKS && !acked; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL rstack_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (dtack === 1'b0) acked = 1;
    end
    n_chk++;
    if (!acked) begin n_bad++; $display("FAIL rstack_no_ack got %b want 0", dtack); end
    dma_req = 1;
    wait_ph(5);
    rst = 1;
    tick();
    n_chk++;
    if (obs !== RST_VEC) begin n_bad++; $display("FAIL rstack_vals got %b want %b", obs, RST_VEC); end
    rst = 0;
    for (int i = 0; i < 3 * SLOT_CLKS; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL rstack_hold_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (dtack === 1'b0 || cpu_gnt === 1'b1) bad_cyc++;
    end
    n_chk++;
    if (bad_cyc != 0) begin n_bad++; $display("FAIL rstack_stale_cpu got %0d want 0", bad_cyc); end
    dma_req = 0; cpu_sel = 0;
    tick();
    cpu_sel = 1;
    for (int i = 0; i < 3 * SLOT_CLKS; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL rstack_new_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (cpu_gnt === 1'b1) gnt = 1;
      if (dtack === 1'b0) ack2 = 1;
    end
    n_chk++;
    if (!(gnt && ack2)) begin n_bad++; $display("FAIL rstack_new_cycle got %b%b want 11", gnt, ack2); end
    cpu_sel = 0;
  endtask

  task automatic test_abort();
    bit got_g = 0;
    int dt_low = 0;
    for (int i = 0; i < SLOT_CLKS; i++) tick();
    wait_ph(3);
    cpu_sel = 1; xrdy = 1;
    for (int i = 0; i < 2 * SLOT_CLKS && !got_g; i++) begin
      tick();
      if (cpu_gnt === 1'b1) got_g = 1;
    end
    n_chk++;
    if (!got_g) begin n_bad++; $display("FAIL abort_grant got 0 want 1"); end
    wait_ph(3);
    cpu_sel = 0;
    for (int i = 0; i < 2 * SLOT_CLKS; i++) begin
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL abort_model cyc %0d got %b want %b", i, obs, mvec()); end
      if (i == 1) begin
        n_chk++;
        if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL abort_slot_owned got %b want 1", cpu_gnt); end
      end
      if (dtack === 1'b0) dt_low++;
    end
    n_chk++;
    if (dt_low != 0) begin n_bad++; $display("FAIL abort_dtack got %0d want 0", dt_low); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      dma_req    = ($urandom_range(0, 2) == 0);
      dma_urgent = ($urandom_range(0, 3) == 0);
      xrdy       = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) == 0) cpu_sel = ~cpu_sel;
      tick();
      n_chk++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL random_model cyc %0d got %b want %b", i, obs, mvec()); end
    end
    rst = 0; dma_req = 0; cpu_sel = 0; dma_urgent = 0; xrdy = 1;
  endtask

  initial begin
    test_reset();
    test_cpu_single();
    test_wait_states();
    test_dma_priority();
    test_reset_mid_ack();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/chipbus_slot_arbiter.md
# chipbus_slot_arbiter

Sequences the shared chip-RAM/custom-register bus between Agnus DMA and the 68000. It divides the 28.63636 MHz master clock into colour-clock slots of 8 CLK each and grants every slot to exactly one owner. DMA has priority. The block drives `_DBR` back to the PALEN-side logic and generates chip-space `_DTACK` for CPU cycles, honouring `XRDY` wait states. It sits between the clock generator, Agnus (`Amiga_8361`) and the PALEN/PALCAS decode.

## Interface
Parameters:
- `SLOT_CLKS`, 8: CLK cycles per bus slot. Must be a power of two, ≥4.
- `MAX_WAIT`, 3: consecutive denied CPU slots before the fairness override applies (feature-gated).

Ports:
- `CLK` in 1: master clock, 28.63636 MHz, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `DMA_REQ` in 1: Agnus requests the next slot. Sampled at phase 0.
- `DMA_URGENT` in 1: the request cannot be deferred (refresh/bitplane). Sampled at phase 0.
- `CPU_SEL` in 1: CPU chip-space cycle pending (`_AS` low qualified by `_RGAE`/`_DAE`). Level.
- `XRDY` in 1: external ready, active-high. Sampled at phase `SLOT_CLKS-2`.
- `SLOT_PH` out log2(`SLOT_CLKS`): current slot phase counter.
- `SLOT_START` out 1: one-CLK pulse at phase 0.
- `DMA_GNT` out 1: DMA owns the current slot.
- `CPU_GNT` out 1: CPU owns the current slot.
- `DMA_MISS` out 1: one-CLK pulse when a sampled `DMA_REQ` was not granted.
- `_DBR` out 1: active-low. DMA holds the bus while the CPU is waiting.
- `_DTACK` out 1: active-low CPU cycle acknowledge.

## Operation
- Phase counter: wraps from `SLOT_CLKS-1` to 0. `SLOT_START` = (phase==0).
- Owner decision, registered at phase 0 and held for the whole slot:
  1. Extension pending → CPU.
  2. `DMA_REQ` → DMA.
  3. Else if `CPU_SEL` and no CPU cycle already acknowledged → CPU.
  4. Else idle (both grants low).
- `DMA_MISS` pulses at phase 0 when `DMA_REQ` was high and the DMA was not granted.
- States:
  - IDLE → CPU_ACC or DMA_ACC at phase 0.
  - DMA_ACC → decide again at the next phase 0.
  - CPU_ACC at phase `SLOT_CLKS-2`:
    - `XRDY`=1 → ACKED. `_DTACK` goes low on the next CLK.
    - `XRDY`=0 → set extension. The next slot is CPU_ACC; the DMA is denied.
  - ACKED: `_DTACK` held low until `CPU_SEL` falls, then high on the next CLK → IDLE. Slots may go to DMA while in ACKED; a new CPU grant requires `CPU_SEL` to have been low at least one CLK.
- `_DBR` = low when `DMA_GNT` and `CPU_SEL` and not ACKED. Otherwise high. Registered.
- Deny counter (saturating, width log2(`MAX_WAIT`)+1):
  - Increments at phase 0 when `CPU_SEL` is pending and DMA wins.
  - Clears on a CPU grant or when `CPU_SEL` is low.
- `CPU_SEL` dropping mid-CPU_ACC (aborted cycle): the slot finishes as owned, no `_DTACK`, extension cleared, → IDLE.
- `DMA_REQ` and `CPU_SEL` rising together: DMA wins, unless the fairness override applies.

## Timing
- Reset values (all outputs, taking effect in the same cycle `RST` is sampled):
  - `SLOT_PH`=0
  - `SLOT_START`=0
  - `DMA_GNT`=0, `CPU_GNT`=0, `DMA_MISS`=0
  - `_DBR`=1, `_DTACK`=1
  - state IDLE, deny counter 0, extension cleared
- The first `SLOT_START` occurs on the first CLK after `RST` deasserts.
- Reset asserted mid-slot aborts any cycle immediately. `_DTACK` never glitches low.
- Grant latency: request valid on the CLK before phase 0 → grant is visible in the phase-0 cycle.
- `_DTACK` latency: CPU slot start → `_DTACK` low after `SLOT_CLKS-1` CLKs (7 by default).
- Each `XRDY`-low sample adds one full slot (`SLOT_CLKS` CLKs).
- The extension is unlimited while `XRDY` stays low. Each extended slot pulses `DMA_MISS` if `DMA_REQ` is high.

## Configuration
- `CHIPBUS_ARB_FAIRNESS_EN` defined:
  - When the deny counter ≥ `MAX_WAIT` at phase 0, `CPU_SEL` is pending and `DMA_URGENT`=0, the CPU wins over `DMA_REQ`. `DMA_MISS` pulses.
  - `DMA_URGENT`=1 always wins. The extension still outranks everything.
- Undefined: strict DMA priority. The deny counter and `MAX_WAIT` are not built, and `DMA_URGENT` is ignored.

## Test plan
- Reset, then 16 CLK idle → `SLOT_START` pulses at CLK 1 and CLK 9. Grants stay 0, `_DBR`=1, `_DTACK`=1.
- `CPU_SEL`=1 only, `XRDY`=1 → `CPU_GNT` at phase 0 and `_DTACK` low 7 CLK later. Drop `CPU_SEL` → `_DTACK`=1 on the next CLK.
- `CPU_SEL`=1 with `XRDY`=0 for 2 samples, then 1 → `_DTACK` low after 23 CLK. A concurrent `DMA_REQ` produces 2 `DMA_MISS` pulses.
- `DMA_REQ` and `CPU_SEL` both held high, fairness off → DMA owns every slot, `_DBR`=0 throughout, no `_DTACK`.
- Same stimulus with `CHIPBUS_ARB_FAIRNESS_EN`, `MAX_WAIT`=3, `DMA_URGENT`=0 → the 4th slot goes to CPU with one `DMA_MISS`. With `DMA_URGENT`=1, no CPU slot is granted.
- `RST` asserted at phase 5 of an ACKED CPU cycle → all outputs at reset values on the next CLK. No `_DTACK` after release until a new `CPU_SEL` rising edge.
